dcache_l2_responder: RTL and testbench
======================================

// Module: dcache_l2_responder
// PURPOSE
//  L2-side responder for the D-cache miss/writeback interface. Serves line-fill requests and accepts
//  dirty-line writebacks from one L1 D-cache, backed by an on-chip line store with a fixed,
//  parameterised access latency. Sits between the D-cache and main memory in FPGA builds.
// PARAMETERS
//  data_width     32    word width; line = block_size*data_width bits
//  address_width  32    byte address width seen by L1
//  block_size     32    words per line
//  mem_depth      1024  lines in the backing store, power of 2; index = low log2(mem_depth) bits of line address
//  latency        4     service cycles per request, >=2
// PORTS
//  CLK               in   1              single clock, rising edge
//  RSTN              in   1              asynchronous, active-low reset
//  ADDR_FROM_L1      in   LA             line address of fill request; LA = address_width-offset_width
//  ADDR_FROM_L1_VALID in  1              fill request, level; one request per rising edge of the level
//  DATA_TO_L1        out  block_size*data_width  fill data
//  DATA_TO_L1_VALID  out  1              one-cycle pulse, DATA_TO_L1 valid
//  WADDR_FROM_L1     in   LA             writeback line address
//  WDATA_FROM_L1     in   block_size*data_width  writeback line data
//  WDATA_FROM_L1_VALID in 1              writeback request, level; held high by L1, possibly many cycles
//  WRITE_DONE        out  1              one-cycle pulse, writeback committed to the store
//  BUSY              out  1              a request is pending or in service
//  OVERRUN           out  1              sticky: a request arrived while the same kind was already pending
// BEHAVIOUR
//  - Reset (RSTN=0, async): all outputs 0, FSM IDLE, pending flags and edge detectors cleared.
//    Store contents are not cleared. Reset mid-service drops the request silently, with no pulse.
//  - Capture: a request is captured on the edge where its valid is high and its previous-cycle sample was low.
//    Address and data are latched at that edge; L1 may change them afterwards.
//    WDATA_FROM_L1_VALID held high is one writeback until it drops low.
//  - A capture while the same kind is already pending is ignored and sets OVERRUN, which clears only on reset.
//  - FSM states:
//    - IDLE -> WB_SVC if a writeback is pending, else -> RD_SVC if a read is pending. The selection is made
//      at the capture edge itself, so a lone request starts with zero added delay.
//    - WB_SVC: count down latency cycles, then write the store. WRITE_DONE pulses in the cycle after
//      edge k+latency, where k is the start edge. Go to RD_SVC if a read is pending, else IDLE.
//    - RD_SVC: issue the store read latency-1 cycles after the start edge (store read takes 1 cycle).
//      Register the line into DATA_TO_L1 at edge k+latency and pulse DATA_TO_L1_VALID in that cycle.
//      Go to WB_SVC if a writeback is pending, else IDLE.
//  - Priority: writeback before read whenever both are pending (including simultaneous capture). A read of
//    a line being written back therefore returns the new data.
//  - Back-to-back: the next service starts at the edge after the completing pulse.
//    Simultaneous captures at edge k give WRITE_DONE after edge k+latency and DATA_TO_L1_VALID after edge
//    k+2*latency+1.
//  - Writeback captured during RD_SVC stays pending and does not preempt; it starts after the read pulse.
//  - DATA_TO_L1 holds its last value between pulses.
//  - BUSY = state!=IDLE | any pending flag, registered.
//  - Index = ADDR[log2(mem_depth)-1:0]. Upper address bits are ignored, so an aliased index returns the last
//    line written there.
//  - Counter width clog2(latency+1), no wrap. Pulses are never longer than one cycle.
// STRUCTURE
//  - Shared package/include dcache_l2_defs: FSM state encodings (IDLE, WB_SVC, RD_SVC);
//    offset_width = clog2(data_width*block_size/8); line-address width.
//    The same geometry localparams are used by the D-cache.
//  - One sub-module: existing MEMORY (sync write, 1-cycle registered read),
//    data_width=block_size*data_width, depth=mem_depth.
//  - This block contains the FSM, the latency counter, the two capture/edge-detect registers and the response
//    register only.
// TESTING
//  1 Reset: RSTN=0 mid-RD_SVC -> all outputs 0 immediately; after release no DATA_TO_L1_VALID pulse; BUSY=0.
//  2 Write then read: WB addr 0x0123, data line with word i = 0xA5000000+i, valid held 10 cycles
//    -> one WRITE_DONE at capture+4. Then read 0x0123 -> DATA_TO_L1_VALID one cycle at capture+4, data matches.
//  3 Simultaneous: WB 0x0040 and read 0x0040 at the same edge -> WRITE_DONE at +4, read pulse at +9 returning
//    the newly written line.
//  4 Overrun: two read pulses 2 cycles apart -> one response only, OVERRUN=1 and sticky until reset.
//  5 Alias: WB 0x0005, then WB 0x0405 with different data, read 0x0005 -> returns the 0x0405 data
//    (mem_depth=1024).
//  6 Latency sweep latency=2 and 7: random 200-request mix against a scoreboard
//    -> every pulse exactly latency after its service start, pulses never wider than 1 cycle.

Source files
------------

// File: rtl/dcache_l2_defs_pkg.sv
// Shared D-cache / L2 geometry and the responder FSM state encoding.
// The D-cache imports the same geometry so both sides agree on line-address width.
package dcache_l2_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB_SVC = 2'd1,
      RD_SVC = 2'd2
   } svc_state_e;

   function automatic int offset_width(input int dw, input int bs);
      return $clog2(dw * bs / 8);
   endfunction

   localparam int DATA_WIDTH      = 32;
   localparam int ADDRESS_WIDTH   = 32;
   localparam int BLOCK_SIZE      = 32;
   localparam int OFFSET_WIDTH    = offset_width(DATA_WIDTH, BLOCK_SIZE);
   localparam int LINE_ADDR_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;

endpackage

// File: rtl/dcache_l2_responder_memory.sv
// Line store: synchronous write, one-cycle registered read.
module MEMORY #(
   parameter int data_width = 1024,
   parameter int depth      = 1024,
   localparam int AW        = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [data_width-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [data_width-1:0] rdata
);

   logic [data_width-1:0] mem_q [depth];
   logic [data_width-1:0] rdata_q;

   // NOTE: storage arrays take no reset; contents survive RSTN and only written lines are ever trusted.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dcache_l2_responder.sv
// L2-side responder: captures fill/writeback requests from one L1 D-cache and services them
// against the line store with a fixed latency, writebacks first.
module dcache_l2_responder
   import dcache_l2_defs::*;
#(
   parameter int data_width    = DATA_WIDTH,
   parameter int address_width = ADDRESS_WIDTH,
   parameter int block_size    = BLOCK_SIZE,
   parameter int mem_depth     = 1024,
   parameter int latency       = 4,
   localparam int LW           = data_width * block_size,
   localparam int LA           = address_width - offset_width(data_width, block_size)
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic [LA-1:0] ADDR_FROM_L1,
   input  logic          ADDR_FROM_L1_VALID,
   output logic [LW-1:0] DATA_TO_L1,
   output logic          DATA_TO_L1_VALID,
   input  logic [LA-1:0] WADDR_FROM_L1,
   input  logic [LW-1:0] WDATA_FROM_L1,
   input  logic          WDATA_FROM_L1_VALID,
   output logic          WRITE_DONE,
   output logic          BUSY,
   output logic          OVERRUN
);

   localparam int IW = $clog2(mem_depth);
   localparam int CW = $clog2(latency + 1);
   localparam logic [CW-1:0] LAT_C = CW'(latency);
   localparam logic [CW-1:0] RD_ISSUE_C = CW'(latency - 1);

   svc_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wb_prev_q, rd_prev_q;
   logic          wb_pend_q, wb_pend_d, rd_pend_q, rd_pend_d;
   logic [IW-1:0] wb_idx_q, wb_idx_d, rd_idx_q, rd_idx_d;
   logic [LW-1:0] wb_line_q, wb_line_d;
   logic [LW-1:0] data_q, data_d;
   logic          data_vld_q, data_vld_d, wdone_q, wdone_d;
   logic          busy_q, busy_d, ovr_q, ovr_d;
   logic          wb_cap, rd_cap, mem_we, mem_re;
   logic [LW-1:0] mem_rdata;

   assign wb_cap = WDATA_FROM_L1_VALID & ~wb_prev_q;
   assign rd_cap = ADDR_FROM_L1_VALID & ~rd_prev_q;

   // NOTE: every _d takes a default before any branch, so this block cannot infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wb_pend_d  = wb_pend_q;
      rd_pend_d  = rd_pend_q;
      wb_idx_d   = wb_idx_q;
      rd_idx_d   = rd_idx_q;
      wb_line_d  = wb_line_q;
      data_d     = data_q;
      data_vld_d = 1'b0;
      wdone_d    = 1'b0;
      ovr_d      = ovr_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;

      // The in-service request stays pending until its pulse, so a second one of that kind is an overrun.
      if (wb_cap) begin
         if (wb_pend_q) ovr_d = 1'b1;
         else begin
            wb_pend_d = 1'b1;
            wb_idx_d  = WADDR_FROM_L1[IW-1:0];
            wb_line_d = WDATA_FROM_L1;
         end
      end
      if (rd_cap) begin
         if (rd_pend_q) ovr_d = 1'b1;
         else begin
            rd_pend_d = 1'b1;
            rd_idx_d  = ADDR_FROM_L1[IW-1:0];
         end
      end

      case (state_q)
         IDLE: begin
            if (wb_pend_d) begin
               state_d = WB_SVC;
               cnt_d   = CW'(1);
            end else if (rd_pend_d) begin
               state_d = RD_SVC;
               cnt_d   = CW'(1);
            end
         end
         WB_SVC: begin
            if (cnt_q == LAT_C) begin
               mem_we    = 1'b1;
               wdone_d   = 1'b1;
               wb_pend_d = 1'b0;
               cnt_d     = '0;
               state_d   = rd_pend_d ? RD_SVC : IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_SVC: begin
            mem_re = (cnt_q == RD_ISSUE_C);
            if (cnt_q == LAT_C) begin
               data_d     = mem_rdata;
               data_vld_d = 1'b1;
               rd_pend_d  = 1'b0;
               cnt_d      = '0;
               state_d    = wb_pend_d ? WB_SVC : IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) | wb_pend_d | rd_pend_d;
   end

   // NOTE: state registers use non-blocking assignments only; the blocking ones live in always_comb.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_prev_q  <= 1'b0;
         rd_prev_q  <= 1'b0;
         wb_pend_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         data_q     <= '0;
         data_vld_q <= 1'b0;
         wdone_q    <= 1'b0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_prev_q  <= WDATA_FROM_L1_VALID;
         rd_prev_q  <= ADDR_FROM_L1_VALID;
         wb_pend_q  <= wb_pend_d;
         rd_pend_q  <= rd_pend_d;
         data_q     <= data_d;
         data_vld_q <= data_vld_d;
         wdone_q    <= wdone_d;
         busy_q     <= busy_d;
         ovr_q      <= ovr_d;
      end
   end

   // Captured address/line are only consumed after a capture has loaded them.
   always_ff @(posedge CLK) begin
      wb_idx_q  <= wb_idx_d;
      rd_idx_q  <= rd_idx_d;
      wb_line_q <= wb_line_d;
   end

   MEMORY #(
      .data_width(LW),
      .depth     (mem_depth)
   ) u_store (
      .clk  (CLK),
      .we   (mem_we),
      .waddr(wb_idx_q),
      .wdata(wb_line_q),
      .re   (mem_re),
      .raddr(rd_idx_q),
      .rdata(mem_rdata)
   );

   generate
      if (LA > IW) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^{ADDR_FROM_L1[LA-1:IW], WADDR_FROM_L1[LA-1:IW]};
      end
   endgenerate

   assign DATA_TO_L1       = data_q;
   assign DATA_TO_L1_VALID = data_vld_q;
   assign WRITE_DONE       = wdone_q;
   assign BUSY             = busy_q;
   assign OVERRUN          = ovr_q;

endmodule

// File: tb/tb_dcache_l2_responder.sv
// Directed checks on a latency-4 responder plus a random sweep of latency-2/7 responders
// against an event-level model (service start + latency -> pulse edge).
module tb_dcache_l2_responder;

   localparam int LW4 = 1024;
   localparam int LA4 = 25;
   localparam int LWS = 128;
   localparam int LAS = 28;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // latency-4 directed DUT
   logic [LA4-1:0] d_addr = '0, d_waddr = '0;
   logic [LW4-1:0] d_wdata = '0;
   logic           d_avld = 1'b0, d_wvld = 1'b0;
   logic [LW4-1:0] o4_data;
   logic           o4_dv, o4_wd, o4_busy, o4_ovr;

   // latency-2 and latency-7 sweep DUTs share stimulus
   logic [LAS-1:0] s_addr = '0, s_waddr = '0;
   logic [LWS-1:0] s_wdata = '0;
   logic           s_avld = 1'b0, s_wvld = 1'b0;
   logic [LWS-1:0] os_data [2];
   logic           os_dv [2], os_wd [2], os_busy [2], os_ovr [2];

   dcache_l2_responder u4 (
      .CLK(CLK), .RSTN(RSTN),
      .ADDR_FROM_L1(d_addr), .ADDR_FROM_L1_VALID(d_avld),
      .DATA_TO_L1(o4_data), .DATA_TO_L1_VALID(o4_dv),
      .WADDR_FROM_L1(d_waddr), .WDATA_FROM_L1(d_wdata), .WDATA_FROM_L1_VALID(d_wvld),
      .WRITE_DONE(o4_wd), .BUSY(o4_busy), .OVERRUN(o4_ovr)
   );

   dcache_l2_responder #(.block_size(4), .mem_depth(16), .latency(2)) u2 (
      .CLK(CLK), .RSTN(RSTN),
      .ADDR_FROM_L1(s_addr), .ADDR_FROM_L1_VALID(s_avld),
      .DATA_TO_L1(os_data[0]), .DATA_TO_L1_VALID(os_dv[0]),
      .WADDR_FROM_L1(s_waddr), .WDATA_FROM_L1(s_wdata), .WDATA_FROM_L1_VALID(s_wvld),
      .WRITE_DONE(os_wd[0]), .BUSY(os_busy[0]), .OVERRUN(os_ovr[0])
   );

   dcache_l2_responder #(.block_size(4), .mem_depth(16), .latency(7)) u7 (
      .CLK(CLK), .RSTN(RSTN),
      .ADDR_FROM_L1(s_addr), .ADDR_FROM_L1_VALID(s_avld),
      .DATA_TO_L1(os_data[1]), .DATA_TO_L1_VALID(os_dv[1]),
      .WADDR_FROM_L1(s_waddr), .WDATA_FROM_L1(s_wdata), .WDATA_FROM_L1_VALID(s_wvld),
      .WRITE_DONE(os_wd[1]), .BUSY(os_busy[1]), .OVERRUN(os_ovr[1])
   );

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs[255:0], exp[255:0]);
      end
   endtask

   // Runs n cycles on the latency-4 DUT; relative edge of each pulse counted from the capture edge.
   task automatic window(input int n, input int wh, input int ah,
                         output int wd_n, output int wd_at, output int rv_n, output int rv_at);
      wd_n = 0; wd_at = -1; rv_n = 0; rv_at = -1;
      for (int j = 1; j <= n; j++) begin
         @(negedge CLK);
         if (j == wh) d_wvld = 1'b0;
         if (j == ah) d_avld = 1'b0;
         if (o4_wd) begin wd_n++; wd_at = j - 1; end
         if (o4_dv) begin rv_n++; rv_at = j - 1; end
      end
   endtask

   // Sweep reference model, one slot per latency
   int             lat [2] = '{2, 7};
   int             m_kind [2];
   int             m_done [2];
   bit             m_wbp [2], m_rdp [2], m_ovr [2];
   logic [3:0]     m_wbi [2], m_rdi [2];
   logic [LWS-1:0] m_wbl [2], m_data [2];
   logic [LWS-1:0] m_mem [2][16];
   bit             m_known [2][16];
   bit             m_dknown [2];
   bit             exp_wd [2], exp_rv [2];

   task automatic model_step(input int d, input int t, input bit wcap, input bit acap);
      int just;
      exp_wd[d] = 1'b0;
      exp_rv[d] = 1'b0;
      just = 0;
      if (wcap) begin
         if (m_wbp[d]) m_ovr[d] = 1'b1;
         else begin m_wbp[d] = 1'b1; m_wbi[d] = s_waddr[3:0]; m_wbl[d] = s_wdata; end
      end
      if (acap) begin
         if (m_rdp[d]) m_ovr[d] = 1'b1;
         else begin m_rdp[d] = 1'b1; m_rdi[d] = s_addr[3:0]; end
      end
      if (m_kind[d] != 0 && t == m_done[d]) begin
         if (m_kind[d] == 1) begin
            m_mem[d][m_wbi[d]]   = m_wbl[d];
            m_known[d][m_wbi[d]] = 1'b1;
            exp_wd[d] = 1'b1;
            m_wbp[d]  = 1'b0;
         end else begin
            m_data[d]   = m_mem[d][m_rdi[d]];
            m_dknown[d] = m_known[d][m_rdi[d]];
            exp_rv[d]   = 1'b1;
            m_rdp[d]    = 1'b0;
         end
         m_kind[d] = 0;
         just = 1;
      end
      if (m_kind[d] == 0) begin
         if (m_wbp[d]) begin m_kind[d] = 1; m_done[d] = t + just + lat[d]; end
         else if (m_rdp[d]) begin m_kind[d] = 2; m_done[d] = t + just + lat[d]; end
      end
   endtask

   initial begin
      logic [LW4-1:0] line_a, line_b, line_c, line_d;
      int wd_n, wd_at, rv_n, rv_at, rv_n2;
      int nreq, whold, ahold, drain;
      bit wprev, aprev, wcap, acap;

      for (int i = 0; i < 32; i++) begin
         line_a[i*32 +: 32] = 32'hA500_0000 + i;
         line_b[i*32 +: 32] = 32'h3C00_0000 + 3 * i;
         line_c[i*32 +: 32] = 32'h1111_0000 ^ i;
         line_d[i*32 +: 32] = 32'h7E00_0000 + 5 * i;
      end

      // Reset state
      #1;
      check("rst_wd", o4_wd, 0);
      check("rst_dv", o4_dv, 0);
      check("rst_data", o4_data, 0);
      check("rst_busy", o4_busy, 0);
      check("rst_ovr", o4_ovr, 0);
      repeat (3) @(negedge CLK);
      RSTN = 1'b1;
      repeat (2) @(negedge CLK);

      // Write then read, valid held 10 cycles counts as one writeback
      d_waddr = 25'h0123; d_wdata = line_a; d_wvld = 1'b1;
      window(16, 10, 0, wd_n, wd_at, rv_n, rv_at);
      check("t2_wd_count", wd_n, 1);
      check("t2_wd_at", wd_at, 4);
      d_addr = 25'h0123; d_avld = 1'b1;
      window(12, 0, 1, wd_n, wd_at, rv_n, rv_at);
      check("t2_rv_count", rv_n, 1);
      check("t2_rv_at", rv_at, 4);
      check("t2_data", o4_data, line_a);
      check("t2_busy_idle", o4_busy, 0);

      // Simultaneous writeback and read of the same line
      d_waddr = 25'h0040; d_wdata = line_b; d_wvld = 1'b1;
      d_addr = 25'h0040; d_avld = 1'b1;
      window(20, 2, 1, wd_n, wd_at, rv_n, rv_at);
      check("t3_wd_at", wd_at, 4);
      check("t3_wd_count", wd_n, 1);
      check("t3_rv_at", rv_at, 9);
      check("t3_rv_count", rv_n, 1);
      check("t3_data", o4_data, line_b);
      check("t3_ovr", o4_ovr, 0);

      // Overrun: second read two cycles after the first
      d_addr = 25'h0123; d_avld = 1'b1;
      window(2, 0, 1, wd_n, wd_at, rv_n, rv_at);
      d_avld = 1'b1;
      window(12, 0, 1, wd_n, wd_at, rv_n2, rv_at);
      check("t4_rv_count", rv_n + rv_n2, 1);
      check("t4_rv_at", rv_at, 2);
      check("t4_data", o4_data, line_a);
      check("t4_ovr", o4_ovr, 1);
      d_addr = 25'h0040; d_avld = 1'b1;
      window(10, 0, 1, wd_n, wd_at, rv_n, rv_at);
      check("t4_ovr_sticky", o4_ovr, 1);
      check("t4_next_data", o4_data, line_b);

      // Alias: 0x0405 lands on the same index as 0x0005
      d_waddr = 25'h0005; d_wdata = line_c; d_wvld = 1'b1;
      window(8, 1, 0, wd_n, wd_at, rv_n, rv_at);
      d_waddr = 25'h0405; d_wdata = line_d; d_wvld = 1'b1;
      window(8, 1, 0, wd_n, wd_at, rv_n, rv_at);
      d_addr = 25'h0005; d_avld = 1'b1;
      window(10, 0, 1, wd_n, wd_at, rv_n, rv_at);
      check("t5_rv_count", rv_n, 1);
      check("t5_alias_data", o4_data, line_d);

      // Reset mid-RD_SVC
      d_addr = 25'h0123; d_avld = 1'b1;
      @(negedge CLK);
      d_avld = 1'b0;
      @(negedge CLK);
      check("t1_busy_before", o4_busy, 1);
      #1 RSTN = 1'b0;
      #1;
      check("t1_rst_wd", o4_wd, 0);
      check("t1_rst_dv", o4_dv, 0);
      check("t1_rst_data", o4_data, 0);
      check("t1_rst_busy", o4_busy, 0);
      check("t1_rst_ovr", o4_ovr, 0);
      @(negedge CLK);
      RSTN = 1'b1;
      window(10, 0, 0, wd_n, wd_at, rv_n, rv_at);
      check("t1_no_pulse", rv_n, 0);
      check("t1_busy_after", o4_busy, 0);

      // Random sweep, latency 2 and 7
      for (int d = 0; d < 2; d++) begin
         m_kind[d] = 0; m_done[d] = 0; m_wbp[d] = 0; m_rdp[d] = 0; m_ovr[d] = 0;
         m_data[d] = '0; m_dknown[d] = 1'b1;
         for (int i = 0; i < 16; i++) m_known[d][i] = 1'b0;
      end
      nreq = 0; whold = 0; ahold = 0; drain = 0; wprev = 0; aprev = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (nreq < 200) begin
            if (!s_wvld) begin
               if ($urandom_range(0, 5) == 0) begin
                  s_wvld = 1'b1; s_waddr = LAS'($urandom);
                  s_wdata = {$urandom, $urandom, $urandom, $urandom};
                  whold = $urandom_range(1, 8); nreq++;
               end
            end else begin
               s_wdata = {$urandom, $urandom, $urandom, $urandom};
               s_waddr = LAS'($urandom);
               whold--;
               if (whold == 0) s_wvld = 1'b0;
            end
            if (!s_avld) begin
               if ($urandom_range(0, 5) == 0) begin
                  s_avld = 1'b1; s_addr = LAS'($urandom);
                  ahold = $urandom_range(1, 3); nreq++;
               end
            end else begin
               s_addr = LAS'($urandom);
               ahold--;
               if (ahold == 0) s_avld = 1'b0;
            end
         end else begin
            s_wvld = 1'b0; s_avld = 1'b0;
            drain++;
         end
         wcap = s_wvld && !wprev;
         acap = s_avld && !aprev;
         for (int d = 0; d < 2; d++) model_step(d, cyc, wcap, acap);
         wprev = s_wvld; aprev = s_avld;
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            check(d ? "L7_wdone" : "L2_wdone", os_wd[d], exp_wd[d]);
            check(d ? "L7_dvalid" : "L2_dvalid", os_dv[d], exp_rv[d]);
            check(d ? "L7_busy" : "L2_busy", os_busy[d],
                  (m_kind[d] != 0) || m_wbp[d] || m_rdp[d]);
            check(d ? "L7_overrun" : "L2_overrun", os_ovr[d], m_ovr[d]);
            if (m_dknown[d]) check(d ? "L7_data" : "L2_data", os_data[d], m_data[d]);
         end
         if (drain >= 40) break;
      end
      check("sweep_requests", nreq >= 200, 1);
      check("L2_drained", os_busy[0], 0);
      check("L7_drained", os_busy[1], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
